// File: rtl/pulse_scan_ctrl_pkg.sv
// Shared definitions for the pulse burst sequencer.
// Holds the FSM state encoding (also used by the serial block for status
// readback) and the default handshake timeout.
package pulse_scan_ctrl_pkg;

    localparam int TMO_BX_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_CMPL = 3'd4,
        ST_GAP       = 3'd5
    } scan_state_t;

endpackage

// File: rtl/pulse_scan_ctrl.sv
// Automated burst sequencer feeding comparator_injector.
// On an accepted start, issues num_pulses single-cycle fire_pulse strobes,
// each handshaked against pulser_ready, with gap_bx idle cycles between a
// pulse completing and the next fire. Reports progress, completion and
// handshake timeouts.
//
// Ports:
//   clock        - system clock
//   reset        - asynchronous active-high reset
//   start        - one-cycle start strobe (ignored while busy)
//   abort        - one-cycle abort strobe, wins over start
//   num_pulses   - pulses per burst, sampled on accepted start
//   gap_bx       - idle cycles between pulse completion and next fire
//   pulser_ready - high when the injector is idle
//   fire_pulse   - one-cycle fire strobe
//   busy         - burst in progress
//   done         - sticky burst finished/aborted flag
//   pulses_sent  - completed pulses in current/last burst
//   timeout_err  - sticky: injector never went busy after a fire
module pulse_scan_ctrl
    import pulse_scan_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 8,
    parameter int TMO_BX = TMO_BX_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [GAP_W-1:0] gap_bx,
    input  logic             pulser_ready,
    output logic             fire_pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent,
    output logic             timeout_err
);

    localparam int TMO_W = $clog2(TMO_BX + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_BX - 1);

    scan_state_t      state, state_n;
    logic [CNT_W-1:0] num_lat, num_lat_n;
    logic [GAP_W-1:0] gap_lat, gap_lat_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             busy_n, done_n, tmo_err_n;
    logic [CNT_W-1:0] sent_n;

    always_comb begin
        state_n   = state;
        num_lat_n = num_lat;
        gap_lat_n = gap_lat;
        gap_cnt_n = gap_cnt;
        tmo_cnt_n = tmo_cnt;
        busy_n    = busy;
        done_n    = done;
        tmo_err_n = timeout_err;
        sent_n    = pulses_sent;

        if (abort && state != ST_IDLE) begin
            // Count is kept; a fire already issued but not completed is dropped.
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        tmo_err_n = 1'b0;
                        sent_n    = '0;
                        if (num_pulses == '0) begin
                            done_n = 1'b1;
                        end else begin
                            num_lat_n = num_pulses;
                            gap_lat_n = gap_bx;
                            done_n    = 1'b0;
                            busy_n    = 1'b1;
                            state_n   = ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (pulser_ready) state_n = ST_FIRE;
                end
                ST_FIRE: begin
                    tmo_cnt_n = '0;
                    state_n   = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!pulser_ready) begin
                        state_n = ST_WAIT_CMPL;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        // TMO_BX consecutive ready-high cycles after the fire.
                        tmo_err_n = 1'b1;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        state_n   = ST_IDLE;
                    end else begin
                        tmo_cnt_n = tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_CMPL: begin
                    if (pulser_ready) begin
                        // pulses_sent < num_lat here, so the increment cannot wrap.
                        sent_n = pulses_sent + 1'b1;
                        if (sent_n == num_lat) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end else if (gap_lat == '0) begin
                            state_n = ST_WAIT_RDY;
                        end else begin
                            gap_cnt_n = gap_lat;
                            state_n   = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(1)) state_n = ST_WAIT_RDY;
                    else                      gap_cnt_n = gap_cnt - 1'b1;
                end
                default: begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            num_lat     <= '0;
            gap_lat     <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            pulses_sent <= '0;
            fire_pulse  <= 1'b0;
        end else begin
            state       <= state_n;
            num_lat     <= num_lat_n;
            gap_lat     <= gap_lat_n;
            gap_cnt     <= gap_cnt_n;
            tmo_cnt     <= tmo_cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            timeout_err <= tmo_err_n;
            pulses_sent <= sent_n;
            // Registered strobe: high exactly while the state register holds FIRE.
            fire_pulse  <= (state_n == ST_FIRE);
        end
    end

endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// Directed bench for pulse_scan_ctrl with a simple pulser model that drops
// ready for a fixed number of cycles after every fire (or ignores fires).
module tb_pulse_scan_ctrl;

    localparam int CNT_W = 16;
    localparam int GAP_W = 8;
    localparam int BUSY_CYC = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] num_pulses = '0;
    logic [GAP_W-1:0] gap_bx = '0;
    logic             pulser_ready = 1'b1;
    logic             fire_pulse, busy, done, timeout_err;
    logic [CNT_W-1:0] pulses_sent;

    int n_chk  = 0;
    int n_pass = 0;

    // pulser model state
    int cyc = 0;
    int fires = 0;
    int bcnt = 0;
    int rise_cyc = -1;
    int spacing = -1;
    bit stuck = 1'b0;
    bit busy_seen = 1'b0;

    pulse_scan_ctrl #(.CNT_W(CNT_W), .GAP_W(GAP_W), .TMO_BX(255)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .num_pulses(num_pulses), .gap_bx(gap_bx), .pulser_ready(pulser_ready),
        .fire_pulse(fire_pulse), .busy(busy), .done(done),
        .pulses_sent(pulses_sent), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (busy) busy_seen = 1'b1;
        if (reset) begin
            pulser_ready = 1'b1;
            bcnt = 0;
        end else if (fire_pulse) begin
            fires = fires + 1;
            if (rise_cyc >= 0) spacing = cyc - rise_cyc;
            if (!stuck) begin
                pulser_ready = 1'b0;
                bcnt = BUSY_CYC;
            end
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) begin
                pulser_ready = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input int n, input int g);
        num_pulses = CNT_W'(n);
        gap_bx = GAP_W'(g);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!(done && !busy) && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (k >= budget) chk({tag, "_wait_expired"}, 32'(k), 32'(budget - 1));
    endtask

    initial begin
        int k;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fire", 32'(fire_pulse), 0);
        chk("rst_sent", 32'(pulses_sent), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // zero-length burst
        busy_seen = 1'b0;
        fires = 0;
        do_start(0, 3);
        chk("zero_done", 32'(done), 1);
        chk("zero_sent", 32'(pulses_sent), 0);
        repeat (5) @(negedge clock);
        chk("zero_busy_seen", 32'(busy_seen), 0);
        chk("zero_fires", 32'(fires), 0);

        // 3 pulses, gap 2, with latency check
        fires = 0;
        rise_cyc = -1;
        spacing = -1;
        do_start(3, 2);
        chk("lat_busy", 32'(busy), 1);
        chk("lat_done_clr", 32'(done), 0);
        chk("lat_fire0", 32'(fire_pulse), 0);
        @(negedge clock);
        chk("lat_fire1", 32'(fire_pulse), 1);
        wait_done("b3", 200);
        // ready rise at X: GAP X+1,X+2, WAIT_RDY X+3, FIRE X+4
        chk("b3_spacing", 32'(spacing), 4);
        chk("b3_fires", 32'(fires), 3);
        chk("b3_sent", 32'(pulses_sent), 3);
        chk("b3_done", 32'(done), 1);
        chk("b3_busy", 32'(busy), 0);
        chk("b3_tmo", 32'(timeout_err), 0);

        // stuck-ready timeout
        stuck = 1'b1;
        fires = 0;
        do_start(1, 0);
        k = 0;
        while (!fire_pulse && k < 10) begin @(negedge clock); k++; end
        chk("tmo_fire_seen", 32'(fire_pulse), 1);
        k = 0;
        while (!timeout_err && k < 300) begin @(negedge clock); k++; end
        // 255 WAIT_ACK cycles after the FIRE cycle, flag visible on the next
        chk("tmo_cycles", 32'(k), 256);
        chk("tmo_done", 32'(done), 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_sent", 32'(pulses_sent), 0);
        stuck = 1'b0;
        @(negedge clock);

        // abort after 4th completion of a 10-pulse burst
        fires = 0;
        do_start(10, 0);
        chk("ab_tmo_clr", 32'(timeout_err), 0);
        k = 0;
        while (pulses_sent != 4 && k < 200) begin @(negedge clock); k++; end
        chk("ab_reach4", 32'(pulses_sent), 4);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 1);
        chk("ab_sent", 32'(pulses_sent), 4);
        repeat (20) @(negedge clock);
        chk("ab_fires", 32'(fires), 4);

        // start+abort same cycle in IDLE: start dropped
        abort = 1'b1;
        do_start(3, 0);
        abort = 1'b0;
        repeat (10) @(negedge clock);
        chk("sa_busy", 32'(busy), 0);
        chk("sa_sent", 32'(pulses_sent), 4);
        chk("sa_fires", 32'(fires), 4);

        // restart while busy is ignored
        fires = 0;
        do_start(5, 1);
        repeat (3) @(negedge clock);
        do_start(9, 0);
        wait_done("rb", 300);
        chk("rb_sent", 32'(pulses_sent), 5);
        chk("rb_fires", 32'(fires), 5);

        // async reset during WAIT_CMPL
        do_start(3, 0);
        k = 0;
        while (pulses_sent != 1 && k < 100) begin @(negedge clock); k++; end
        k = 0;
        while (!fire_pulse && k < 20) begin @(negedge clock); k++; end
        repeat (3) @(negedge clock);
        chk("rs_pre_busy", 32'(busy), 1);
        chk("rs_pre_sent", 32'(pulses_sent), 1);
        #2 reset = 1'b1;
        #1;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_sent", 32'(pulses_sent), 0);
        chk("rs_done", 32'(done), 0);
        chk("rs_fire", 32'(fire_pulse), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        fires = 0;
        do_start(2, 0);
        wait_done("rs2", 100);
        chk("rs2_sent", 32'(pulses_sent), 2);
        chk("rs2_fires", 32'(fires), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
